// File: rtl/router_local_input_unit.sv
// Local-port input buffer: DEPTH-entry FWFT FIFO fed by the PE, returns one credit per drained flit.
// Latency: push to out_valid 1 cycle; pop to credit_out 1 cycle.
// Backpressure: out_ready low holds the head flit; the PE is throttled by credits, and overflowing flits are dropped.
// Optional feature macro: ROUTER_IN_ERR_CHECK_EN adds the sticky err_overflow port and an overflow assertion.
module router_local_input_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in_data,
  output logic                       credit_out,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  input  logic                       out_ready,
`ifdef ROUTER_IN_ERR_CHECK_EN
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       err_overflow
`else
  output logic [$clog2(DEPTH):0]     occupancy
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  credit_q, credit_d;
  logic                  push, pop;

  // Head flit is presented straight from the array (first-word fall-through).
  assign out_valid  = (count_q != '0);
  assign out_data   = mem_q[rd_ptr_q];
  assign occupancy  = count_q;
  assign credit_out = credit_q;

  // Handshake decode and next-state for pointers, count and credit.
  always_comb begin
    pop      = out_valid && out_ready;
    // A full buffer still accepts a flit when the head leaves in the same cycle.
    push     = in_valid && ((count_q < CW'(DEPTH)) || pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    credit_d = pop;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state register; contents of the array are deliberately not reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      credit_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      credit_q <= credit_d;
    end
  end

  // Flit storage write port.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef ROUTER_IN_ERR_CHECK_EN
  logic overflow;
  logic err_q, err_d;

  assign err_overflow = err_q;

  // A valid flit that was not accepted can only mean full with no pop: flag it until reset.
  always_comb begin
    overflow = in_valid && !push;
    err_d    = err_q || overflow;
  end

  // Sticky overflow flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

`ifndef SYNTHESIS
  // The PE should never send without a credit; catch it loudly in simulation.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !overflow)
    else $error("router_local_input_unit: flit dropped on overflow");
`endif
`endif

endmodule

// File: tb/tb_router_local_input_unit.sv
// Self-checking bench for router_local_input_unit against a queue-based reference model.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: random out_ready plus directed full/overflow scenarios.
module tb_router_local_input_unit;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          credit_out;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [CW-1:0] occupancy;
`ifdef ROUTER_IN_ERR_CHECK_EN
  logic          err_overflow;
`endif

  router_local_input_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .credit_out   (credit_out),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
`ifdef ROUTER_IN_ERR_CHECK_EN
    .occupancy    (occupancy),
    .err_overflow (err_overflow)
`else
    .occupancy    (occupancy)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the stored flits in arrival order, the credit expected this cycle, sticky error.
  logic [DW-1:0] model_q[$];
  logic          exp_credit = 1'b0;
  logic          exp_err = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".occupancy"}, 64'(occupancy), 64'(model_q.size()));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() != 0));
    check({tag, ".credit_out"}, 64'(credit_out), 64'(exp_credit));
    if (model_q.size() != 0) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(model_q[0]));
    end
`ifdef ROUTER_IN_ERR_CHECK_EN
    check({tag, ".err_overflow"}, 64'(err_overflow), 64'(exp_err));
`endif
  endtask

  // One clock cycle: drive inputs, predict from the queue, advance, then compare.
  task automatic cycle(input string tag, input logic v, input logic [DW-1:0] d, input logic r);
    bit do_pop, do_push;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_pop  = (model_q.size() != 0) && r;
    do_push = v && ((model_q.size() < DEPTH) || do_pop);
    if (v && !do_push) exp_err = 1'b1;
    @(posedge clk);
    #1;
    if (do_pop) void'(model_q.pop_front());
    if (do_push) model_q.push_back(d);
    exp_credit = do_pop;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_outputs(tag);
  endtask

  task automatic model_reset();
    model_q.delete();
    exp_credit = 1'b0;
    exp_err    = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] c6;
    c6 = 32'hC6;

    // 1. Reset state, then 5 idle cycles.
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) cycle("idle", 1'b0, '0, 1'b0);

    // 2. Fill with out_ready low, then drain.
    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, DW'(32'hA1 + i), 1'b0);
    check("fill.full", 64'(occupancy), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check("drain.head", 64'(out_data), 64'(32'hA1 + i));
      cycle("drain", 1'b0, '0, 1'b1);
    end
    cycle("drain.tail", 1'b0, '0, 1'b0);
    check("drain.empty", 64'(occupancy), 64'd0);

    // 3. Streaming with out_ready held high.
    for (int i = 0; i < 20; i++) cycle("stream", 1'b1, DW'(32'h100 + i), 1'b1);
    check("stream.occ", 64'(occupancy), 64'd1);
    cycle("stream.end", 1'b0, '0, 1'b1);

    // 4. Full with simultaneous pop.
    for (int i = 0; i < 4; i++) cycle("full.fill", 1'b1, DW'(32'hB1 + i), 1'b0);
    cycle("full.pushpop", 1'b1, DW'(32'hB5), 1'b1);
    check("full.occ", 64'(occupancy), 64'd4);

    // 5. Overflow while full and stalled: C6 must be dropped.
    cycle("ovf", 1'b1, c6, 1'b0);
    check("ovf.occ", 64'(occupancy), 64'd4);
    cycle("ovf.hold", 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check("ovf.no_c6", 64'(out_valid && (out_data == c6)), 64'd0);
      cycle("ovf.drain", 1'b0, '0, 1'b1);
    end

    // 6. Asynchronous reset with 3 flits stored and a credit pulse pending.
    for (int i = 0; i < 4; i++) cycle("mid.fill", 1'b1, DW'(32'hD0 + i), 1'b0);
    cycle("mid.pop", 1'b0, '0, 1'b1);
    check("mid.pending", 64'(credit_out), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("mid.async");
    @(posedge clk);
    #1;
    check_outputs("mid.held");
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cycle("mid.after", 1'b0, '0, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic v, r;
      v = ($urandom_range(0, 99) < 60);
      r = ($urandom_range(0, 99) < 55);
      cycle("rand", v, DW'($urandom), r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
